// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one fixed-latency single-port memory between
// instruction fetch and load/store; data has fixed priority over fetch.
module mem_arbiter #(
    parameter int READ_LAT = 1,
    parameter int MASK_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [MASK_W-1:0] d_mask,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [MASK_W-1:0] mem_mask,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] LAT = 3'(READ_LAT);

    state_t              r_state;
    logic                r_gnt_d;
    logic [2:0]          r_cnt;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [MASK_W-1:0]   r_mem_mask;
    logic                r_if_ack;
    logic                r_d_ack;
    logic [31:0]         r_if_rdata;
    logic [31:0]         r_d_rdata;
    logic [31:0]         r_stall_cnt;

    logic                w_srv_d;
    logic                w_srv_if;
    logic                w_stall;

    // Which requester is being served this cycle; in IDLE this is the grant about to be made.
    always_comb begin
        w_srv_d  = 1'b0;
        w_srv_if = 1'b0;
        if (r_state == ST_IDLE) begin
            w_srv_d  = d_req;
            w_srv_if = if_req & ~d_req;
        end else begin
            w_srv_d  = r_gnt_d;
            w_srv_if = ~r_gnt_d;
        end
    end

    assign w_stall = (if_req & ~w_srv_if) | (d_req & ~w_srv_d);

    // Arbitration FSM with registered memory strobes, acks, read-data holds and stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_gnt_d     <= 1'b0;
            r_cnt       <= 3'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_mask  <= '0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_d_rdata   <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 32'd0;
            r_mem_mask  <= '0;
            if (r_if_ack) begin
                r_if_rdata <= mem_rdata;
            end
            if (r_d_ack) begin
                r_d_rdata <= mem_rdata;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (d_req) begin
                        r_gnt_d     <= 1'b1;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_mask  <= d_mask;
                        // A store commits in its issue cycle, so its ack lines up with mem_en.
                        r_d_ack     <= d_we;
                        r_state     <= ST_ISSUE;
                    end else if (if_req) begin
                        r_gnt_d     <= 1'b0;
                        r_mem_en    <= 1'b1;
                        r_mem_addr  <= if_addr;
                        r_state     <= ST_ISSUE;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (r_mem_we) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= LAT;
                        if (LAT == 3'd1) begin
                            r_d_ack  <= r_gnt_d;
                            r_if_ack <= ~r_gnt_d;
                        end
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Ack is registered one cycle early so it coincides with the final count.
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd2) begin
                        r_d_ack  <= r_gnt_d;
                        r_if_ack <= ~r_gnt_d;
                    end
                    if (r_cnt <= 3'd1) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_ack    = r_if_ack;
    assign d_ack     = r_d_ack;
    assign if_rdata  = r_if_ack ? mem_rdata : r_if_rdata;
    assign d_rdata   = r_d_ack  ? mem_rdata : r_d_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_mask  = r_mem_mask;
    assign stall_cnt = r_stall_cnt;

endmodule
